// File: rtl/acc_regfile.sv
// acc_regfile: accelerator register file with per-register outstanding-result
// scoreboard, FPU writeback port, host preload port and stall-aware read port.
module acc_regfile #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_tag_i,
  output logic              issue_ready_o,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_waddr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ready_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              host_wr;
  logic              issue_acc;
  logic [CNT_W-1:0]  rd_cnt;

  // Handshake strobes: FPU writeback owns the write port; saturation blocks issue.
  always_comb begin
    host_ready_o  = !wren_i;
    host_wr       = host_we_i && !wren_i;
    issue_ready_o = (cnt_q[issue_tag_i] != CNT_MAX);
    issue_acc     = issue_valid_i && issue_ready_o;
    rd_cnt        = cnt_q[raddr_i];
  end

  // Storage write: FPU writeback first, otherwise an accepted host write.
  always_comb begin
    regs_d = regs_q;
    if (wren_i) begin
      regs_d[waddr_i] = wdata_i;
    end else if (host_we_i) begin
      regs_d[host_waddr_i] = host_wdata_i;
    end
  end

  // Outstanding-result counters and sticky orphan-writeback flag.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic inc, dec;
      inc      = issue_acc && (issue_tag_i == ADDR_W'(i));
      dec      = wren_i && (waddr_i == ADDR_W'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    if (wren_i && (cnt_q[waddr_i] == '0)) begin
      err_d = 1'b1;
    end
    if (flush_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_d[i] = '0;
      end
      err_d = 1'b0;
    end
  end

  // Read port: valid only when no result is pending, with write-to-read bypass.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ren_i &&
               ((rd_cnt == '0) ||
                ((rd_cnt == CNT_W'(1)) && wren_i && (waddr_i == raddr_i) &&
                 !(issue_valid_i && (issue_tag_i == raddr_i))));
    if (rvalid_d) begin
      if (wren_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else if (host_wr && (host_waddr_i == raddr_i)) begin
        rdata_d = host_wdata_i;
      end else begin
        rdata_d = regs_q[raddr_i];
      end
    end
  end

  // Any register with a result still in flight.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_o = busy_o | (cnt_q[i] != '0);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_acc_regfile.sv
// Directed self-checking bench for acc_regfile.
module tb_acc_regfile;

  localparam int unsigned NUM_REGS = 64;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned ADDR_W   = 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              ren_i;
  logic [ADDR_W-1:0] raddr_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              issue_valid_i;
  logic [ADDR_W-1:0] issue_tag_i;
  logic              issue_ready_o;
  logic              wren_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_waddr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_ready_o;
  logic              flush_i;
  logic              busy_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  acc_regfile #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .issue_valid_i(issue_valid_i), .issue_tag_i(issue_tag_i),
    .issue_ready_o(issue_ready_o),
    .wren_i(wren_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .host_we_i(host_we_i), .host_waddr_i(host_waddr_i),
    .host_wdata_i(host_wdata_i), .host_ready_o(host_ready_o),
    .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs changed afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ren_i = 1'b0; issue_valid_i = 1'b0; wren_i = 1'b0;
    host_we_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    raddr_i = '0; issue_tag_i = '0; waddr_i = '0; wdata_i = '0;
    host_waddr_i = '0; host_wdata_i = '0;
    step(); step();
    rst_i = 1'b0;
    step();
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_issue_ready", 32'(issue_ready_o), 32'h1);
    check("rst_host_ready", 32'(host_ready_o), 32'h1);

    // Host preload and read-back.
    host_we_i = 1'b1; host_waddr_i = 6'd5; host_wdata_i = 32'h3F800000;
    step();
    host_we_i = 1'b0; ren_i = 1'b1; raddr_i = 6'd5;
    step();
    check("host_rd_valid", 32'(rvalid_o), 32'h1);
    check("host_rd_data", rdata_o, 32'h3F800000);
    check("host_rd_err", 32'(err_o), 32'h0);
    ren_i = 1'b0;

    // Two results in flight on tag 7; read held until both return.
    issue_valid_i = 1'b1; issue_tag_i = 6'd7;
    step(); step();
    issue_valid_i = 1'b0; ren_i = 1'b1; raddr_i = 6'd7;
    step();
    check("pend_rvalid", 32'(rvalid_o), 32'h0);
    check("pend_busy", 32'(busy_o), 32'h1);
    wren_i = 1'b1; waddr_i = 6'd7; wdata_i = 32'h40000000;
    step();
    check("pend_wb1_rvalid", 32'(rvalid_o), 32'h0);
    wdata_i = 32'h40400000;
    step();
    check("pend_wb2_rvalid", 32'(rvalid_o), 32'h1);
    check("pend_wb2_data", rdata_o, 32'h40400000);
    wren_i = 1'b0;
    step();
    check("pend_after_rvalid", 32'(rvalid_o), 32'h1);
    check("pend_after_data", rdata_o, 32'h40400000);
    check("pend_after_busy", 32'(busy_o), 32'h0);
    ren_i = 1'b0;

    // Saturation on tag 3.
    issue_valid_i = 1'b1; issue_tag_i = 6'd3;
    step(); step(); step();
    check("sat_ready", 32'(issue_ready_o), 32'h0);
    step();                                   // held issue ignored at cnt=3
    check("sat_hold_ready", 32'(issue_ready_o), 32'h0);
    // Issue blocked at saturation while a writeback drains one: cnt 3 -> 2.
    wren_i = 1'b1; waddr_i = 6'd3; wdata_i = 32'h11;
    #1;
    check("sat_wb_ready_c", 32'(issue_ready_o), 32'h0);
    step();
    check("sat_wb_ready", 32'(issue_ready_o), 32'h1);
    // Accepted issue plus writeback: cnt stays 2.
    step();
    check("sat_incdec_ready", 32'(issue_ready_o), 32'h1);
    issue_valid_i = 1'b0;
    // Drain two more: read must come back valid after the second.
    ren_i = 1'b1; raddr_i = 6'd3; wdata_i = 32'h22;
    step();
    check("sat_drain1_rvalid", 32'(rvalid_o), 32'h0);
    wdata_i = 32'h33;
    step();
    check("sat_drain2_rvalid", 32'(rvalid_o), 32'h1);
    check("sat_drain2_data", rdata_o, 32'h33);
    wren_i = 1'b0; ren_i = 1'b0;
    step();
    check("sat_busy", 32'(busy_o), 32'h0);
    check("sat_err", 32'(err_o), 32'h0);

    // Host write loses to FPU writeback, lands once wren drops.
    wren_i = 1'b1; waddr_i = 6'd10; wdata_i = 32'hAAAA5555;
    host_we_i = 1'b1; host_waddr_i = 6'd9; host_wdata_i = 32'h12345678;
    #1;
    check("prio_host_ready0", 32'(host_ready_o), 32'h0);
    step();
    wren_i = 1'b0;
    #1;
    check("prio_host_ready1", 32'(host_ready_o), 32'h1);
    step();
    host_we_i = 1'b0; ren_i = 1'b1; raddr_i = 6'd9;
    step();
    check("prio_rd9", rdata_o, 32'h12345678);
    raddr_i = 6'd10;
    step();
    check("prio_rd10", rdata_o, 32'hAAAA5555);
    check("prio_err", 32'(err_o), 32'h1);      // reg 10 had no issue
    ren_i = 1'b0;

    // Host-write bypass onto a same-cycle read.
    host_we_i = 1'b1; host_waddr_i = 6'd20; host_wdata_i = 32'h77;
    ren_i = 1'b1; raddr_i = 6'd20;
    step();
    check("host_bypass", rdata_o, 32'h77);
    idle();

    // Flush, then orphan writeback on reg 2, then flush again.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush1_err", 32'(err_o), 32'h0);
    wren_i = 1'b1; waddr_i = 6'd2; wdata_i = 32'h55;
    step();
    wren_i = 1'b0;
    check("orphan_err", 32'(err_o), 32'h1);
    issue_valid_i = 1'b1; issue_tag_i = 6'd8;
    step();
    issue_valid_i = 1'b0;
    check("pre_flush_busy", 32'(busy_o), 32'h1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush2_err", 32'(err_o), 32'h0);
    check("flush2_busy", 32'(busy_o), 32'h0);
    ren_i = 1'b1; raddr_i = 6'd2;
    step();
    check("flush_keep2", rdata_o, 32'h55);
    raddr_i = 6'd5;
    step();
    check("flush_keep5", rdata_o, 32'h3F800000);
    ren_i = 1'b0;

    // Reset mid-flight drops tracking; late writeback flags an error.
    issue_valid_i = 1'b1; issue_tag_i = 6'd4;
    step();
    issue_valid_i = 1'b0;
    check("rst_mid_busy1", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_busy0", 32'(busy_o), 32'h0);
    step();
    rst_i = 1'b0;
    wren_i = 1'b1; waddr_i = 6'd4; wdata_i = 32'h99;
    step();
    wren_i = 1'b0;
    check("late_wb_err", 32'(err_o), 32'h1);
    ren_i = 1'b1; raddr_i = 6'd5;
    step();
    check("rst_clear_rvalid", 32'(rvalid_o), 32'h1);
    check("rst_clear_data", rdata_o, 32'h0);
    ren_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
